// File: rtl/sqrt_pkg.sv
// Shared constants and width helpers for the pipelined integer square root.
package sqrt_pkg;

  localparam int ROUND_FLOOR   = 0;
  localparam int ROUND_NEAREST = 1;

  function automatic int res_w(input int din_w);
    return (din_w + 1) / 2;
  endfunction

  function automatic int dout_w(input int din_w);
    return (din_w + 2) / 2;
  endfunction

  function automatic int rem_w(input int din_w);
    return res_w(din_w) + 1;
  endfunction

endpackage

// File: rtl/sqrt_stage.sv
// One registered step of the subtract-based square-root recurrence: takes the
// top bit pair of the remaining radicand and appends one root bit.
module sqrt_stage #(
  parameter int RES_W = 11,
  parameter int TAG_W = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ce,
  input  logic               i_valid,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic [RES_W-1:0]   i_q,
  input  logic [RES_W+1:0]   i_r,
  input  logic [2*RES_W-1:0] i_x,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag,
  output logic [RES_W-1:0]   o_q,
  output logic [RES_W+1:0]   o_r,
  output logic [2*RES_W-1:0] o_x
);

  logic [RES_W+1:0] w_r_shift;
  logic [RES_W+1:0] w_trial;
  logic [RES_W+1:0] w_r_next;
  logic [RES_W-1:0] w_q_next;
  logic             w_ge;

  // Trial subtraction of (4q+1) from the shifted partial remainder
  always_comb begin
    w_r_shift = (i_r << 2'd2) | {{RES_W{1'b0}}, i_x[2*RES_W-1 -: 2]};
    w_trial   = {i_q, 2'b01};
    w_ge      = (w_r_shift >= w_trial);
    w_q_next  = i_q << 1'd1;
    if (w_ge) begin
      w_r_next    = w_r_shift - w_trial;
      w_q_next[0] = 1'b1;
    end else begin
      w_r_next    = w_r_shift;
    end
  end

  // Stage register; holds while the pipeline is stalled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_tag   <= '0;
      o_q     <= '0;
      o_r     <= '0;
      o_x     <= '0;
    end else if (i_ce) begin
      o_valid <= i_valid;
      o_tag   <= i_tag;
      o_q     <= w_q_next;
      o_r     <= w_r_next;
      o_x     <= i_x << 2'd2;
    end
  end

endmodule

// File: rtl/sqrt_pipe.sv
// Fully pipelined integer square root with floor/round-to-nearest result,
// remainder, sideband tag and a globally stalling valid/ready handshake.
module sqrt_pipe
  import sqrt_pkg::*;
#(
  parameter int DIN_W      = 21,
  parameter int ROUND_MODE = ROUND_NEAREST,
  parameter int TAG_W      = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [DIN_W-1:0]         din,
  input  logic [TAG_W-1:0]         din_tag,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [dout_w(DIN_W)-1:0] dout,
  output logic [rem_w(DIN_W)-1:0]  dout_rem,
  output logic [TAG_W-1:0]         dout_tag,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  localparam int RES_W  = res_w(DIN_W);
  localparam int DOUT_W = dout_w(DIN_W);
  localparam int REM_W  = rem_w(DIN_W);
  localparam int PAD_W  = 2 * RES_W;

  logic                w_ce;
  logic                r_in_valid;
  logic [TAG_W-1:0]    r_in_tag;
  logic [PAD_W-1:0]    r_in_x;

  logic                w_valid [0:RES_W];
  logic [TAG_W-1:0]    w_tag   [0:RES_W];
  logic [RES_W-1:0]    w_q     [0:RES_W];
  logic [RES_W+1:0]    w_r     [0:RES_W];
  logic [PAD_W-1:0]    w_x     [0:RES_W];

  logic [DOUT_W-1:0]   w_root;
  logic [DOUT_W-1:0]   r_dout;
  logic [REM_W-1:0]    r_dout_rem;
  logic [TAG_W-1:0]    r_dout_tag;
  logic                r_dout_valid;

  // A single enable stalls every stage together, so bubbles are kept
  assign w_ce      = dout_ready | ~r_dout_valid;
  assign din_ready = w_ce;

  // Input capture register; radicand zero-extended to an even width
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_in_valid <= 1'b0;
      r_in_tag   <= '0;
      r_in_x     <= '0;
    end else if (w_ce) begin
      r_in_valid <= din_valid;
      r_in_tag   <= din_tag;
      r_in_x     <= PAD_W'(din);
    end
  end

  assign w_valid[0] = r_in_valid;
  assign w_tag[0]   = r_in_tag;
  assign w_q[0]     = '0;
  assign w_r[0]     = '0;
  assign w_x[0]     = r_in_x;

  for (genvar g = 0; g < RES_W; g++) begin : g_stage
    sqrt_stage #(
      .RES_W (RES_W),
      .TAG_W (TAG_W)
    ) u_stage (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_ce    (w_ce),
      .i_valid (w_valid[g]),
      .i_tag   (w_tag[g]),
      .i_q     (w_q[g]),
      .i_r     (w_r[g]),
      .i_x     (w_x[g]),
      .o_valid (w_valid[g+1]),
      .o_tag   (w_tag[g+1]),
      .o_q     (w_q[g+1]),
      .o_r     (w_r[g+1]),
      .o_x     (w_x[g+1])
    );
  end

  // Round up when the floor remainder exceeds the floor root (no ties exist)
  always_comb begin
    w_root = DOUT_W'(w_q[RES_W]);
    if ((ROUND_MODE == ROUND_NEAREST) && (w_r[RES_W] > {2'b00, w_q[RES_W]})) begin
      w_root = DOUT_W'(w_q[RES_W]) + {{(DOUT_W-1){1'b0}}, 1'b1};
    end else begin
      w_root = DOUT_W'(w_q[RES_W]);
    end
  end

  // Registered output stage
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dout       <= '0;
      r_dout_rem   <= '0;
      r_dout_tag   <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_ce) begin
      r_dout       <= w_root;
      r_dout_rem   <= w_r[RES_W][REM_W-1:0];
      r_dout_tag   <= w_tag[RES_W];
      r_dout_valid <= w_valid[RES_W];
    end
  end

  assign dout       = r_dout;
  assign dout_rem   = r_dout_rem;
  assign dout_tag   = r_dout_tag;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_sqrt_pipe.sv
// Self-checking bench: 21-bit and 16-bit instances in floor and rounding modes,
// directed vectors, backpressure, full-rate stream and mid-stream reset.
module tb_sqrt_pipe;

  localparam int TW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [20:0] din;
  logic [TW-1:0] din_tag;
  logic        din_valid;
  logic        dout_ready;
  logic        din_valid16;

  logic        din_ready21r, din_ready21f, din_ready16r, din_ready16f;
  logic [10:0] dout21r, dout21f;
  logic [11:0] rem21r, rem21f;
  logic [8:0]  dout16r, dout16f;
  logic [8:0]  rem16r, rem16f;
  logic [TW-1:0] tag21r, tag21f, tag16r, tag16f;
  logic        v21r, v21f, v16r, v16f;

  always #5 clk = ~clk;

  // 16-bit instances take exactly the samples the 21-bit ones accept
  assign din_valid16 = din_valid & din_ready21r;

  sqrt_pipe #(.DIN_W(21), .ROUND_MODE(1), .TAG_W(TW)) dut21r (
    .sys_clk(clk), .sys_rst_n(rst_n), .din(din), .din_tag(din_tag), .din_valid(din_valid),
    .din_ready(din_ready21r), .dout(dout21r), .dout_rem(rem21r), .dout_tag(tag21r),
    .dout_valid(v21r), .dout_ready(dout_ready));
  sqrt_pipe #(.DIN_W(21), .ROUND_MODE(0), .TAG_W(TW)) dut21f (
    .sys_clk(clk), .sys_rst_n(rst_n), .din(din), .din_tag(din_tag), .din_valid(din_valid),
    .din_ready(din_ready21f), .dout(dout21f), .dout_rem(rem21f), .dout_tag(tag21f),
    .dout_valid(v21f), .dout_ready(dout_ready));
  sqrt_pipe #(.DIN_W(16), .ROUND_MODE(1), .TAG_W(TW)) dut16r (
    .sys_clk(clk), .sys_rst_n(rst_n), .din(din[15:0]), .din_tag(din_tag), .din_valid(din_valid16),
    .din_ready(din_ready16r), .dout(dout16r), .dout_rem(rem16r), .dout_tag(tag16r),
    .dout_valid(v16r), .dout_ready(1'b1));
  sqrt_pipe #(.DIN_W(16), .ROUND_MODE(0), .TAG_W(TW)) dut16f (
    .sys_clk(clk), .sys_rst_n(rst_n), .din(din[15:0]), .din_tag(din_tag), .din_valid(din_valid16),
    .din_ready(din_ready16f), .dout(dout16f), .dout_rem(rem16f), .dout_tag(tag16f),
    .dout_valid(v16f), .dout_ready(1'b1));

  typedef struct {
    longint x;
    int     tag;
    int     acc_edge;
  } exp_t;

  typedef struct {
    logic [20:0] x;
    longint      fl;
    longint      rm;
    longint      rd;
  } vec_t;

  exp_t   q21[$];
  exp_t   q16[$];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  int     n_out21 = 0;
  int     last_lat21 = 0;
  longint last_d21r, last_r21r, last_d21f, last_r21f;
  longint last_d16r, last_d16f, last_r16r;
  bit     fr_mode = 1'b0;
  bit     fr_first = 1'b1;
  int     fr_prev = 0;
  int     fr_gaps = 0;
  bit     bp_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic longint isqrt(input longint x);
    longint q;
    q = longint'($sqrt(real'(x)));
    while (q * q > x) q--;
    while ((q + 1) * (q + 1) <= x) q++;
    return q;
  endfunction

  // Nearest integer to sqrt(x): step up when x >= (q + 1/2)^2
  function automatic longint iround(input longint x);
    longint q;
    q = isqrt(x);
    return (4 * x >= 4 * q * q + 4 * q + 1) ? q + 1 : q;
  endfunction

  // Scoreboard: checks consumed outputs, the ready rule, and records accepts
  always @(negedge clk) begin : mon
    exp_t   e;
    longint fq;
    if (rst_n) begin
      chk("din_ready_rule", din_ready21r, longint'(!(v21r && !dout_ready)));
      if (q21.size() == 0) begin
        chk("spurious21", v21r, 0);
      end else if (v21r && dout_ready) begin
        e  = q21.pop_front();
        fq = isqrt(e.x);
        chk($sformatf("d21_round x=%0d", e.x), dout21r, iround(e.x));
        chk($sformatf("d21_rem x=%0d", e.x), rem21r, e.x - fq * fq);
        chk($sformatf("d21_tag x=%0d", e.x), tag21r, e.tag);
        chk("d21f_valid", v21f, 1);
        chk($sformatf("d21_floor x=%0d", e.x), dout21f, fq);
        chk($sformatf("d21f_rem x=%0d", e.x), rem21f, e.x - fq * fq);
        chk("d21f_tag", tag21f, e.tag);
        last_lat21 = cyc - e.acc_edge;
        last_d21r  = dout21r;
        last_r21r  = rem21r;
        last_d21f  = dout21f;
        last_r21f  = rem21f;
        n_out21++;
        if (fr_mode) begin
          if (!fr_first && (cyc - fr_prev != 1)) fr_gaps++;
          fr_first = 1'b0;
          fr_prev  = cyc;
        end
      end
      if (q16.size() == 0) begin
        chk("spurious16", v16r, 0);
      end else if (v16r) begin
        e  = q16.pop_front();
        fq = isqrt(e.x);
        chk($sformatf("d16_round x=%0d", e.x), dout16r, iround(e.x));
        chk("d16_rem", rem16r, e.x - fq * fq);
        chk("d16_tag", tag16r, e.tag);
        chk("d16f_valid", v16f, 1);
        chk($sformatf("d16_floor x=%0d", e.x), dout16f, fq);
        chk("d16f_tag", tag16f, e.tag);
        chk("d16_latency", cyc - e.acc_edge, 9);
        last_d16r = dout16r;
        last_d16f = dout16f;
        last_r16r = rem16r;
      end
      if (din_valid && din_ready21r) begin
        q21.push_back('{longint'(din), int'(din_tag), cyc + 1});
        q16.push_back('{longint'(din[15:0]), int'(din_tag), cyc + 1});
      end
    end
  end

  task automatic send_and_wait(input logic [20:0] x, input logic [TW-1:0] t);
    int n0;
    n0 = n_out21;
    din = x; din_tag = t; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    din = 21'($urandom);
    for (int k = 0; k < 40 && n_out21 == n0; k++) @(posedge clk);
    #1;
    if (n_out21 == n0) chk("timeout_directed", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   n0;
    vecs[0] = '{21'd0,       0,    0,   0};
    vecs[1] = '{21'd1,       1,    0,   1};
    vecs[2] = '{21'd1000000, 1000, 0,   1000};
    vecs[3] = '{21'd2096704, 1448, 0,   1448};
    vecs[4] = '{21'd12,      3,    3,   3};
    vecs[5] = '{21'd13,      3,    4,   4};
    vecs[6] = '{21'd2097151, 1448, 447, 1448};
    vecs[7] = '{21'd65535,   255,  510, 256};

    rst_n = 1'b0; din = '0; din_tag = '0; din_valid = 1'b0; dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout21r, 0);
    chk("rst_rem", rem21r, 0);
    chk("rst_tag", tag21r, 0);
    chk("rst_valid", v21r, 0);
    chk("rst_valid16", v16r, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed table: values, remainder, both rounding modes, latency 12
    for (int i = 0; i < 8; i++) begin
      send_and_wait(vecs[i].x, TW'(i));
      chk($sformatf("vec%0d_floor", i), last_d21f, vecs[i].fl);
      chk($sformatf("vec%0d_rem", i), last_r21f, vecs[i].rm);
      chk($sformatf("vec%0d_round", i), last_d21r, vecs[i].rd);
      chk($sformatf("vec%0d_rem_r", i), last_r21r, vecs[i].rm);
      chk($sformatf("vec%0d_latency", i), last_lat21, 12);
    end
    chk("w16_round_65535", last_d16r, 256);
    chk("w16_floor_65535", last_d16f, 255);
    chk("w16_rem_65535", last_r16r, 510);

    // Backpressure burst, tags 0..39, random ready with a 5-cycle hold-off
    n0 = n_out21;
    bp_done = 1'b0;
    fork
      begin
        int acc;
        for (int i = 0; i < 40; i++) begin
          din = 21'($urandom); din_tag = TW'(i); din_valid = 1'b1;
          acc = 0;
          for (int k = 0; k < 200 && acc == 0; k++) begin
            @(negedge clk); acc = int'(din_ready21r);
            @(posedge clk); #1;
          end
          if (acc == 0) chk("timeout_bp_accept", 0, 1);
        end
        din_valid = 1'b0;
        bp_done = 1'b1;
      end
      begin
        int c;
        c = 0;
        while (!bp_done) begin
          @(posedge clk); #1;
          dout_ready = (c >= 12 && c < 17) ? 1'b0 : ($urandom_range(0, 3) != 0);
          c++;
        end
        dout_ready = 1'b1;
      end
    join
    for (int k = 0; k < 100 && q21.size() != 0; k++) @(posedge clk);
    #1;
    chk("bp_drain", q21.size(), 0);
    chk("bp_count", n_out21 - n0, 40);

    // Full-rate stream with ready held high
    n0 = n_out21;
    fr_first = 1'b1; fr_gaps = 0; fr_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case (i % 16)
        0:       din = 21'd0;
        1:       din = 21'h1FFFFF;
        default: din = 21'($urandom);
      endcase
      din_tag = TW'(i); din_valid = 1'b1;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    for (int k = 0; k < 50 && q21.size() != 0; k++) @(posedge clk);
    #1;
    fr_mode = 1'b0;
    chk("fullrate_count", n_out21 - n0, 1000);
    chk("fullrate_gaps", fr_gaps, 0);

    // Reset pulse with samples in flight
    for (int i = 0; i < 16; i++) begin
      din = 21'($urandom); din_tag = TW'(i); din_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre_reset_valid", v21r, 1);
    rst_n = 1'b0;
    din_valid = 1'b0;
    #1;
    chk("async_rst_valid21", v21r, 0);
    chk("async_rst_valid16", v16r, 0);
    chk("async_rst_dout", dout21r, 0);
    q21.delete();
    q16.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_and_wait(21'd500000, 8'hA5);
    chk("post_rst_round", last_d21r, 707);
    chk("post_rst_floor", last_d21f, 707);
    chk("post_rst_rem", last_r21f, 151);
    chk("post_rst_latency", last_lat21, 12);

    repeat (15) @(posedge clk);
    #1;
    chk("final_q21_empty", q21.size(), 0);
    chk("final_q16_empty", q16.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
